// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, TCR/TSR bit positions, divider encoding and reset values for timer_apb_core
package timer_pkg;

  localparam int unsigned ADDR_TDR  = 0;
  localparam int unsigned ADDR_TCR  = 1;
  localparam int unsigned ADDR_TSR  = 2;
  localparam int unsigned ADDR_TCNT = 3;

  localparam int TCR_LOAD   = 7;
  localparam int TCR_UD     = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  // reserved TCR bits 6, 3 and 2 are never stored
  localparam logic [7:0] TCR_WMASK = 8'hB3;

  localparam logic [7:0] TDR_RST  = 8'h00;
  localparam logic [7:0] TCR_RST  = 8'h00;
  localparam logic [7:0] TCNT_RST = 8'h00;
  localparam logic       FLAG_RST = 1'b0;

  typedef enum logic [1:0] {
    DIV1 = 2'd0,
    DIV2 = 2'd1,
    DIV4 = 2'd2,
    DIV8 = 2'd3
  } cks_e;

  function automatic logic [2:0] cks_mask(input cks_e cks);
    case (cks)
      DIV1:    return 3'd0;
      DIV2:    return 3'd1;
      DIV4:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - free-running divide-by-1/2/4/8 tick generator, held at zero while disabled or loading
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESC_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] cks,
  output logic       tick
);

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] mask;
  logic               run;

  assign run  = en & ~clr;
  assign mask = PRESC_W'(cks_mask(cks_e'(cks)));

  // a divider change only swaps the mask; the count itself keeps running
  assign tick = run & ((presc & mask) == mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (!run) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/timer_apb_core.sv
// rtl/timer_apb_core.sv - 8-bit up/down timer with APB registers TDR/TCR/TSR/TCNT
// Optional TIMER_PSLVERR_EN adds pslverr for out-of-map accesses and TCNT writes.
module timer_apb_core
  import timer_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 3
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [CNT_W-1:0]  pwdata,
  output logic [CNT_W-1:0]  prdata,
  output logic              pready,
  output logic              tmr_ovf,
  output logic              tmr_udf
`ifdef TIMER_PSLVERR_EN
  ,
  output logic              pslverr
`endif
);

  logic [CNT_W-1:0] tdr;
  logic [CNT_W-1:0] tcr;
  logic [CNT_W-1:0] tcnt;
  logic             ovf;
  logic             udf;

  logic access, wr_ok, tick;
  logic sel_tdr, sel_tcr, sel_tsr, sel_tcnt;
  logic load, ud, en;
  logic ovf_set, udf_set, ovf_clr, udf_clr;
  logic [CNT_W-1:0] rdata;

  assign access   = psel & penable;
  assign pready   = access;
  assign sel_tdr  = (paddr == ADDR_W'(ADDR_TDR));
  assign sel_tcr  = (paddr == ADDR_W'(ADDR_TCR));
  assign sel_tsr  = (paddr == ADDR_W'(ADDR_TSR));
  assign sel_tcnt = (paddr == ADDR_W'(ADDR_TCNT));

`ifdef TIMER_PSLVERR_EN
  logic err;
  assign err     = access & (~(sel_tdr | sel_tcr | sel_tsr | sel_tcnt) | (pwrite & sel_tcnt));
  assign pslverr = err;
  assign wr_ok   = access & pwrite & ~err;
`else
  assign wr_ok   = access & pwrite;
`endif

  assign load = tcr[TCR_LOAD];
  assign ud   = tcr[TCR_UD];
  assign en   = tcr[TCR_EN];

  timer_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk (pclk),
    .rst (preset),
    .en  (en),
    .clr (load),
    .cks (tcr[TCR_CKS_HI:TCR_CKS_LO]),
    .tick(tick)
  );

  // tick is already suppressed while LOAD is set
  assign ovf_set = tick & ~ud & (tcnt == {CNT_W{1'b1}});
  assign udf_set = tick & ud & (tcnt == '0);
  assign ovf_clr = wr_ok & sel_tsr & pwdata[TSR_OVF];
  assign udf_clr = wr_ok & sel_tsr & pwdata[TSR_UDF];

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tdr <= CNT_W'(TDR_RST);
      tcr <= CNT_W'(TCR_RST);
    end else begin
      if (wr_ok && sel_tdr) tdr <= pwdata;
      if (wr_ok && sel_tcr) tcr <= pwdata & CNT_W'(TCR_WMASK);
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tcnt <= CNT_W'(TCNT_RST);
    end else if (load) begin
      tcnt <= tdr;
    end else if (tick) begin
      tcnt <= ud ? tcnt - 1'b1 : tcnt + 1'b1;
    end
  end

  // a hardware set in the same cycle as a W1C keeps the flag
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      ovf <= FLAG_RST;
      udf <= FLAG_RST;
    end else begin
      ovf <= ovf_set | (ovf & ~ovf_clr);
      udf <= udf_set | (udf & ~udf_clr);
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_tdr)       rdata = tdr;
    else if (sel_tcr)  rdata = tcr;
    else if (sel_tsr)  rdata = CNT_W'({udf, ovf});
    else if (sel_tcnt) rdata = tcnt;
  end

  assign prdata  = (access & ~pwrite) ? rdata : '0;
  assign tmr_ovf = ovf;
  assign tmr_udf = udf;

endmodule
